// File: rtl/dac_module.sv
// Streams 12-bit samples from a valid/ready producer to a parallel DAC through a small FIFO.
// Generates the divided DAC clock and updates the code on its falling edge so it is stable at the DAC's rising-edge latch.
module dac_module #(
    parameter int          CLK         = 60,
    parameter int          DAC_FREQ    = 6,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          PRIME_LEVEL = 4,
    parameter logic [11:0] MID_CODE    = 12'h800
) (
    input  logic        clk_PSRAM,
    input  logic        rst_n,
    input  logic        dac_enable,
    input  logic [11:0] sample_data,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        dac_clk,
    output logic [11:0] dac_data,
    output logic        dac_underrun,
    output logic [7:0]  underrun_count,
    output logic        dac_running
);

    localparam int COUNTER_NUM = CLK / DAC_FREQ;
    localparam int HALF        = COUNTER_NUM / 2;
    localparam int CNT_W       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W       = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [11:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]   count_reg, count_next;
    logic [CNT_W-1:0]   div_reg, div_next;
    logic               dac_clk_reg, dac_clk_next;
    logic [11:0]        data_reg, data_next;
    logic               underrun_reg, underrun_next;
    logic [7:0]         ucount_reg, ucount_next;
    logic               push, pop, flush;

    assign sample_ready   = (state_reg != IDLE) && (count_reg < LVL_W'(FIFO_DEPTH));
    assign push           = sample_valid && sample_ready && dac_enable;
    assign dac_clk        = dac_clk_reg;
    assign dac_data       = data_reg;
    assign dac_underrun   = underrun_reg;
    assign underrun_count = ucount_reg;
    assign dac_running    = (state_reg == RUN);

    always_comb begin
        state_next    = state_reg;
        div_next      = div_reg;
        dac_clk_next  = dac_clk_reg;
        data_next     = data_reg;
        underrun_next = 1'b0;
        ucount_next   = ucount_reg;
        pop           = 1'b0;
        flush         = 1'b0;

        case (state_reg)
            IDLE: begin
                flush        = 1'b1;
                div_next     = '0;
                dac_clk_next = 1'b0;
                data_next    = MID_CODE;
                if (dac_enable) begin
                    state_next = PRIME;
                end
            end
            PRIME: begin
                div_next     = '0;
                dac_clk_next = 1'b0;
                data_next    = MID_CODE;
                if (count_reg >= LVL_W'(PRIME_LEVEL)) begin
                    state_next = RUN;
                    data_next  = mem[rd_ptr_reg];
                    pop        = 1'b1;
                end
            end
            RUN: begin
                if (div_reg == CNT_W'(HALF - 1)) begin
                    div_next     = '0;
                    dac_clk_next = ~dac_clk_reg;
                    // Code changes only on the falling toggle of the DAC clock.
                    if (dac_clk_reg) begin
                        if (count_reg != '0) begin
                            data_next = mem[rd_ptr_reg];
                            pop       = 1'b1;
                        end else begin
                            underrun_next = 1'b1;
                            if (ucount_reg != 8'hFF) begin
                                ucount_next = ucount_reg + 8'd1;
                            end
                        end
                    end
                end else begin
                    div_next = div_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Disable overrides everything: park the outputs and drop buffered data.
        if (!dac_enable) begin
            state_next    = IDLE;
            div_next      = '0;
            dac_clk_next  = 1'b0;
            data_next     = MID_CODE;
            underrun_next = 1'b0;
            ucount_next   = ucount_reg;
            pop           = 1'b0;
            flush         = 1'b1;
        end

        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + LVL_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_PSRAM) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            div_reg      <= '0;
            dac_clk_reg  <= 1'b0;
            data_reg     <= MID_CODE;
            underrun_reg <= 1'b0;
            ucount_reg   <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            div_reg      <= div_next;
            dac_clk_reg  <= dac_clk_next;
            data_reg     <= data_next;
            underrun_reg <= underrun_next;
            ucount_reg   <= ucount_next;
        end
    end

    // Sample storage; pointers are reset, so a write during reset is harmless.
    always_ff @(posedge clk_PSRAM) begin
        if (push && rst_n) begin
            mem[wr_ptr_reg] <= sample_data;
        end
    end

endmodule

// File: tb/tb_dac_module.sv
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))

module tb_dac_module;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, vld_a, ready_a, dclk_a, und_a, run_a;
    logic [11:0] din_a, ddata_a;
    logic [7:0]  ucnt_a;
    logic        en_b, vld_b, ready_b, dclk_b, und_b, run_b;
    logic [11:0] din_b, ddata_b;
    logic [7:0]  ucnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_module #(.CLK(60), .DAC_FREQ(6), .FIFO_DEPTH(8), .PRIME_LEVEL(4), .MID_CODE(12'h800)) u_a (
        .clk_PSRAM(clk), .rst_n(rst_n), .dac_enable(en_a), .sample_data(din_a),
        .sample_valid(vld_a), .sample_ready(ready_a), .dac_clk(dclk_a), .dac_data(ddata_a),
        .dac_underrun(und_a), .underrun_count(ucnt_a), .dac_running(run_a)
    );

    dac_module #(.CLK(60), .DAC_FREQ(6), .FIFO_DEPTH(8), .PRIME_LEVEL(8), .MID_CODE(12'h800)) u_b (
        .clk_PSRAM(clk), .rst_n(rst_n), .dac_enable(en_b), .sample_data(din_b),
        .sample_valid(vld_b), .sample_ready(ready_b), .dac_clk(dclk_b), .dac_data(ddata_b),
        .dac_underrun(und_b), .underrun_count(ucnt_b), .dac_running(run_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("check %s ok: 0x%0h", tag, obs);
        end else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (run_a !== 1'b1) begin
                checks++;
                if (dclk_a !== 1'b0) begin
                    errors++;
                    $error("FAIL mon_a_clk_idle observed=%b expected=0", dclk_a);
                end
            end
            if (run_b !== 1'b1) begin
                checks++;
                if (dclk_b !== 1'b0) begin
                    errors++;
                    $error("FAIL mon_b_clk_idle observed=%b expected=0", dclk_b);
                end
            end
            if (und_a === 1'b1) begin
                checks++;
                if (run_a !== 1'b1) begin
                    errors++;
                    $error("FAIL mon_a_und_run observed=%b expected=1", run_a);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en_a = 1'b0; vld_a = 1'b0; din_a = 12'h000;
        en_b = 1'b0; vld_b = 1'b0; din_b = 12'h000;

        tick(2);
        rst_n = 1'b1;
        tick(3);
        `CHK("idle_clk", dclk_a, 1'b0);
        `CHK("idle_data", ddata_a, 12'h800);
        `CHK("idle_ready", ready_a, 1'b0);
        `CHK("idle_ucnt", ucnt_a, 8'd0);
        `CHK("idle_run", run_a, 1'b0);
        `CHK("idle_und", und_a, 1'b0);

        en_b = 1'b1;
        tick(1);
        `CHK("bp_ready_prime", ready_b, 1'b1);
        vld_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            din_b = 12'h100 + 12'(k);
            tick(1);
        end
        `CHK("bp_ready_full", ready_b, 1'b0);
        `CHK("bp_run_prime", run_b, 1'b0);
        din_b = 12'h108;
        tick(1);
        `CHK("bp_first", ddata_b, 12'h100);
        `CHK("bp_run", run_b, 1'b1);
        `CHK("bp_ready_after_pop", ready_b, 1'b1);
        tick(1);
        vld_b = 1'b0;
        `CHK("bp_ready_refull", ready_b, 1'b0);
        tick(9);
        `CHK("bp_out_1", ddata_b, 12'h101);
        for (int k = 2; k <= 8; k++) begin
            tick(10);
            `CHK("bp_out", ddata_b, 12'h100 + 12'(k));
        end
        en_b = 1'b0;
        tick(1);
        `CHK("idle_still_data", ddata_a, 12'h800);
        `CHK("idle_still_ready", ready_a, 1'b0);
        `CHK("idle_still_clk", dclk_a, 1'b0);

        en_a = 1'b1;
        tick(1);
        vld_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            din_a = 12'(k);
            tick(1);
        end
        vld_a = 1'b0;
        `CHK("prime_run", run_a, 1'b0);
        `CHK("prime_data", ddata_a, 12'h800);
        tick(1);
        `CHK("first_data", ddata_a, 12'h001);
        `CHK("first_run", run_a, 1'b1);
        `CHK("first_clk", dclk_a, 1'b0);
        tick(4);
        `CHK("clk_low_before_rise", dclk_a, 1'b0);
        tick(1);
        `CHK("clk_rise", dclk_a, 1'b1);
        tick(5);
        `CHK("clk_fall", dclk_a, 1'b0);
        `CHK("data_2", ddata_a, 12'h002);
        tick(10);
        `CHK("data_3", ddata_a, 12'h003);
        tick(10);
        `CHK("data_4", ddata_a, 12'h004);

        tick(9);
        `CHK("pre_underrun", und_a, 1'b0);
        tick(1);
        `CHK("underrun_pulse", und_a, 1'b1);
        `CHK("underrun_hold", ddata_a, 12'h004);
        `CHK("underrun_cnt1", ucnt_a, 8'd1);
        tick(1);
        `CHK("underrun_end", und_a, 1'b0);
        tick(3000);
        `CHK("underrun_sat", ucnt_a, 8'd255);
        `CHK("underrun_running", run_a, 1'b1);

        for (int i = 0; i < 20 && dclk_a !== 1'b0; i++) tick(1);
        for (int i = 0; i < 20 && dclk_a !== 1'b1; i++) tick(1);
        `CHK("wait_rise", dclk_a, 1'b1);
        vld_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            din_a = 12'h010 + 12'(k);
            tick(1);
        end
        vld_a = 1'b0;
        `CHK("dis_clk_high", dclk_a, 1'b1);
        en_a = 1'b0;
        tick(1);
        `CHK("dis_clk", dclk_a, 1'b0);
        `CHK("dis_data", ddata_a, 12'h800);
        `CHK("dis_ready", ready_a, 1'b0);
        `CHK("dis_run", run_a, 1'b0);
        `CHK("dis_ucnt_kept", ucnt_a, 8'd255);

        en_a = 1'b1;
        tick(1);
        vld_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            din_a = 12'h020 + 12'(k);
            tick(1);
        end
        vld_a = 1'b0;
        tick(3);
        `CHK("reprime_run", run_a, 1'b0);
        `CHK("reprime_data", ddata_a, 12'h800);
        vld_a = 1'b1;
        din_a = 12'h024;
        tick(1);
        vld_a = 1'b0;
        tick(1);
        `CHK("reprime_first", ddata_a, 12'h021);
        `CHK("reprime_running", run_a, 1'b1);

        vld_a = 1'b1;
        din_a = 12'h0AA;
        rst_n = 1'b0;
        tick(1);
        vld_a = 1'b0;
        `CHK("rst_data", ddata_a, 12'h800);
        `CHK("rst_clk", dclk_a, 1'b0);
        `CHK("rst_run", run_a, 1'b0);
        `CHK("rst_ucnt", ucnt_a, 8'd0);
        `CHK("rst_und", und_a, 1'b0);
        `CHK("rst_ready", ready_a, 1'b0);
        rst_n = 1'b1;
        tick(1);
        vld_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            din_a = 12'h030 + 12'(k);
            tick(1);
        end
        vld_a = 1'b0;
        tick(1);
        `CHK("post_rst_first", ddata_a, 12'h031);
        tick(10);
        `CHK("post_rst_second", ddata_a, 12'h032);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
